sdram_stream_wr: RTL and testbench
==================================

SDRAM_STREAM_WR -- requirements
Module: sdram_stream_wr

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 128, the 32-bit words per full burst (legal 1..255).
REQ-002 SHALL have ports CLK in 1, the single clock; RESET in 1, synchronous active-high reset.
REQ-003 SHALL have ports START in 1, pulse that loads BASE and begins a transfer; BASE in 24, SDRAM halfword start address.
REQ-004 SHALL have ports S_DATA in 32, stream word; S_VALID in 1; S_LAST in 1, last word of transfer; S_READY out 1.
REQ-005 SHALL have ports ACTIVE out 1, transfer in progress; DONE out 1, one-cycle pulse at transfer end; BURSTS out 16, burst count.
REQ-006 SHALL have MAC-side ports M_ADDR out 8, M_WD out 32, M_WE out 1, M_WE_LEN out 1, M_WE_A out 1, M_BUSY in 1.

Function
REQ-007 SHALL implement states IDLE, FILL, SETA, SETL, SETTLE, WAIT.
REQ-008 IDLE: START=1 SHALL load addr<=BASE, clear word count n, and go to FILL; START outside IDLE SHALL be ignored.
REQ-009 FILL: S_READY=1; each S_VALID cycle SHALL drive M_WE=1, M_ADDR=n, M_WD=S_DATA, then n<=n+1.
REQ-010 FILL SHALL go to SETA after accepting word BURST_WORDS or a word with S_LAST=1, latching last flag.
REQ-011 SETA: one cycle, M_WE_A=1, M_WD={8'h00,addr}; then SETL.
REQ-012 SETL: one cycle, M_WE_LEN=1, M_WD[31]=1 (write), M_WD[8:0]=2*n (halfwords), other bits 0; then SETTLE.
REQ-013 SETTLE: one cycle, no strobes, covers the MAC's one-cycle BUSY rise latency; then WAIT.
REQ-014 WAIT: on M_BUSY=0, addr<=addr+2*n (mod 2^24, wraps silently), n<=0; if last flag, DONE=1 for one cycle and go IDLE, else go FILL.
REQ-015 Strobes M_WE, M_WE_LEN, M_WE_A SHALL be mutually exclusive and zero outside their states; M_ADDR/M_WD SHALL be 0 when no strobe.
REQ-016 S_READY SHALL be 0 in every state except FILL; no combinational path S_VALID->S_READY.
REQ-017 ACTIVE SHALL be 1 in every state except IDLE.
REQ-018 START with S_LAST on the first word SHALL produce a 1-word burst (length field 2).
REQ-019 Words arriving while not in FILL SHALL be held by the source (no drop, no overwrite).

Reset
REQ-020 RESET SHALL force IDLE, n=0, addr=0, last flag=0, BURSTS=0, all outputs 0, in the cycle after assertion, including mid-burst.
REQ-021 RESET mid-burst SHALL issue no further MAC strobes; the MAC shares RESET and is idle with it.

Configuration
REQ-022 With SDRAM_STREAM_WR_STATS_EN defined, BURSTS SHALL increment (wrapping 16-bit) on each WAIT->FILL/IDLE exit.
REQ-023 Without SDRAM_STREAM_WR_STATS_EN, BURSTS SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-024 State enum, LEN field position (bits 8:0), write-flag bit (31) and address width (24) SHALL live in shared package sdram_pkg.
REQ-025 No sub-module; single FSM plus counter/address registers in one module.

Verification
REQ-026 BURST_WORDS=4, START BASE=0x000100, 8 words, LAST on 8th -> two bursts: WE_A 0x100/WE_LEN 0x80000008, then WE_A 0x108/WE_LEN 0x80000008; DONE once.
REQ-027 BURST_WORDS=4, 3 words LAST on 3rd -> one burst WE_LEN 0x80000006, M_ADDR 0,1,2; DONE after M_BUSY falls.
REQ-028 BASE=0xFFFFFC, BURST_WORDS=4, 8 words -> second WE_A carries 0x000004 (wrap).
REQ-029 Hold M_BUSY=1 for 50 cycles in WAIT -> S_READY stays 0, no strobes, S_VALID words held; resume on M_BUSY=0.
REQ-030 RESET asserted in SETL -> next cycle all outputs 0, state IDLE; fresh START works normally.
REQ-031 With SDRAM_STREAM_WR_STATS_EN, REQ-026 stimulus -> BURSTS=2; without it -> BURSTS=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared constants and FSM state encoding for the SDRAM stream writer.
// Field positions here describe the MAC length/command word.
package sdram_pkg;
    localparam int ADDR_W      = 24;
    localparam int LEN_MSB     = 8;
    localparam int LEN_LSB     = 0;
    localparam int WR_FLAG_BIT = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SETA,
        ST_SETL,
        ST_SETTLE,
        ST_WAIT
    } state_t;
endpackage

// File: rtl/sdram_stream_wr_if.sv
// Stream-in and MAC-side signals of the SDRAM stream writer.
// The master modport is the writer, and the slave modport is the source/MAC environment.
interface sdram_stream_wr_if;
    logic [31:0] S_DATA;
    logic        S_VALID;
    logic        S_LAST;
    logic        S_READY;
    logic [7:0]  M_ADDR;
    logic [31:0] M_WD;
    logic        M_WE;
    logic        M_WE_LEN;
    logic        M_WE_A;
    logic        M_BUSY;

    modport master (
        input  S_DATA, S_VALID, S_LAST, M_BUSY,
        output S_READY, M_ADDR, M_WD, M_WE, M_WE_LEN, M_WE_A
    );

    modport slave (
        output S_DATA, S_VALID, S_LAST, M_BUSY,
        input  S_READY, M_ADDR, M_WD, M_WE, M_WE_LEN, M_WE_A
    );
endinterface

// File: rtl/sdram_stream_wr.sv
// Packs a 32-bit word stream into MAC bursts of up to BURST_WORDS words, advancing the SDRAM address.
// Define SDRAM_STREAM_WR_STATS_EN to get a wrapping 16-bit completed-burst counter on BURSTS.
module sdram_stream_wr
    import sdram_pkg::*;
#(
    parameter int BURST_WORDS = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE,
    output logic              ACTIVE,
    output logic              DONE,
    output logic [15:0]       BURSTS,
    sdram_stream_wr_if.master bus
);
    localparam logic [7:0] N_FULL = 8'(BURST_WORDS - 1);

    state_t            state, state_nx;
    logic [7:0]        n;
    logic [ADDR_W-1:0] addr;
    logic              last_q;
    logic              take;
    logic              burst_end;

    always_comb begin
        state_nx     = state;
        take         = 1'b0;
        burst_end    = 1'b0;
        ACTIVE       = (state != ST_IDLE);
        DONE         = 1'b0;
        bus.S_READY  = 1'b0;
        bus.M_WE     = 1'b0;
        bus.M_WE_A   = 1'b0;
        bus.M_WE_LEN = 1'b0;
        bus.M_ADDR   = '0;
        bus.M_WD     = '0;
        case (state)
            ST_IDLE: if (START) state_nx = ST_FILL;
            ST_FILL: begin
                // S_READY depends only on state, so the source sees no S_VALID loop
                bus.S_READY = 1'b1;
                if (bus.S_VALID) begin
                    take       = 1'b1;
                    bus.M_WE   = 1'b1;
                    bus.M_ADDR = n;
                    bus.M_WD   = bus.S_DATA;
                    if (bus.S_LAST || n == N_FULL) state_nx = ST_SETA;
                end
            end
            ST_SETA: begin
                bus.M_WE_A = 1'b1;
                bus.M_WD   = {{(32-ADDR_W){1'b0}}, addr};
                state_nx   = ST_SETL;
            end
            ST_SETL: begin
                bus.M_WE_LEN                  = 1'b1;
                bus.M_WD[WR_FLAG_BIT]         = 1'b1;
                bus.M_WD[LEN_MSB:LEN_LSB]     = {n, 1'b0};
                state_nx                      = ST_SETTLE;
            end
            // MAC raises BUSY one cycle after the length strobe
            ST_SETTLE: state_nx = ST_WAIT;
            ST_WAIT: if (!bus.M_BUSY) begin
                burst_end = 1'b1;
                DONE      = last_q;
                state_nx  = last_q ? ST_IDLE : ST_FILL;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            n      <= '0;
            addr   <= '0;
            last_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && START) begin
                addr   <= BASE;
                n      <= '0;
                last_q <= 1'b0;
            end
            if (take) begin
                n      <= n + 8'd1;
                last_q <= bus.S_LAST;
            end
            if (burst_end) begin
                addr <= addr + ADDR_W'({n, 1'b0});
                n    <= '0;
            end
        end
    end

`ifdef SDRAM_STREAM_WR_STATS_EN
    logic [15:0] burst_cnt;
    always_ff @(posedge CLK) begin
        if (RESET)          burst_cnt <= '0;
        else if (burst_end) burst_cnt <= burst_cnt + 16'd1;
    end
    assign BURSTS = burst_cnt;
`else
    assign BURSTS = '0;
`endif
endmodule

// File: tb/tb_sdram_stream_wr.sv
// Randomized bench for sdram_stream_wr: expected MAC strobe sequence is derived from the
// transfer length and base address; a small MAC model holds BUSY for a chosen time.
module tb_sdram_stream_wr;
    localparam int BW = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [23:0] BASE = '0;
    logic        ACTIVE, DONE;
    logic [15:0] BURSTS;

    sdram_stream_wr_if bus();

    sdram_stream_wr #(.BURST_WORDS(BW)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASE(BASE),
        .ACTIVE(ACTIVE), .DONE(DONE), .BURSTS(BURSTS), .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  kind;   // 0 WE, 1 WE_A, 2 WE_LEN, 3 DONE
        logic [7:0]  addr;
        logic [31:0] data;
    } ev_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_bursts = 0;
    ev_t         obs_q[$];
    ev_t         exp_q[$];
    logic [31:0] obs_a[$];
    logic [31:0] obs_len[$];
    logic [31:0] words[$];

    // Reference: split nw words into chunks of BW, address advances by 2*chunk halfwords.
    task automatic model(input logic [23:0] base, input int nw);
        int          i = 0;
        logic [23:0] a = base;
        exp_q.delete();
        while (i < nw) begin
            int k = (nw - i < BW) ? nw - i : BW;
            for (int j = 0; j < k; j++) exp_q.push_back('{2'd0, 8'(j), words[i+j]});
            exp_q.push_back('{2'd1, 8'd0, {8'h00, a}});
            exp_q.push_back('{2'd2, 8'd0, 32'h8000_0000 | 32'(2 * k)});
            a = a + 24'(2 * k);
            i += k;
            exp_bursts++;
        end
        exp_q.push_back('{2'd3, 8'd0, 32'd0});
    endtask

    task automatic run_transfer(input logic [23:0] base, input int nw, input int busy_len,
                                input int vpct, input bit stop_at_len);
        int   idx = 0, busy_cnt = 0, cyc = 0, nstb;
        bit   done_seen = 0, post_len = 0, presented = 0, accept, len_seen;
        logic [15:0] exp_b;
        obs_q.delete(); obs_a.delete(); obs_len.delete(); words.delete();
        for (int i = 0; i < nw; i++) words.push_back($urandom);
        model(base, nw);
        while (!done_seen && cyc < 3000) begin
            @(negedge CLK);
            START = (cyc == 0);
            BASE  = (cyc == 0) ? base : 24'($urandom);
            bus.M_BUSY = (busy_cnt > 0);
            if (post_len && busy_cnt == 0) post_len = 0;
            if (!presented && idx < nw && $urandom_range(0, 99) < vpct) presented = 1;
            bus.S_VALID = presented;
            bus.S_DATA  = presented ? words[idx] : $urandom;
            bus.S_LAST  = presented ? (idx == nw - 1) : 1'($urandom_range(0, 1));
            #1;
            nstb = int'(bus.M_WE) + int'(bus.M_WE_A) + int'(bus.M_WE_LEN);
            n_chk++;
            if (nstb > 1) begin
                n_fail++; $display("FAIL strobe_mutex: got %0d strobes, want at most 1", nstb);
            end
            n_chk++;
            if (nstb == 0 && (bus.M_ADDR !== 8'd0 || bus.M_WD !== 32'd0)) begin
                n_fail++; $display("FAIL idle_bus: got addr %h wd %h, want 0", bus.M_ADDR, bus.M_WD);
            end
            n_chk++;
            if (ACTIVE !== (cyc > 0)) begin
                n_fail++; $display("FAIL active: cycle %0d got %b want %b", cyc, ACTIVE, cyc > 0);
            end
            if (post_len && bus.M_BUSY) begin
                n_chk++;
                if (bus.S_READY !== 1'b0 || nstb != 0) begin
                    n_fail++; $display("FAIL busy_hold: got ready %b strobes %0d, want 0 0", bus.S_READY, nstb);
                end
            end
            if (bus.M_WE) obs_q.push_back('{2'd0, bus.M_ADDR, bus.M_WD});
            if (bus.M_WE_A) begin obs_q.push_back('{2'd1, 8'd0, bus.M_WD}); obs_a.push_back(bus.M_WD); end
            if (bus.M_WE_LEN) begin obs_q.push_back('{2'd2, 8'd0, bus.M_WD}); obs_len.push_back(bus.M_WD); end
            if (DONE) begin
                obs_q.push_back('{2'd3, 8'd0, 32'd0});
                done_seen = 1;
                n_chk++;
                if (bus.M_BUSY !== 1'b0) begin
                    n_fail++; $display("FAIL done_busy: got busy %b at DONE, want 0", bus.M_BUSY);
                end
            end
            accept   = bus.S_VALID && bus.S_READY;
            len_seen = bus.M_WE_LEN;
            if (stop_at_len && len_seen) return;
            @(posedge CLK);
            if (accept) begin idx++; presented = 0; end
            if (busy_cnt > 0) busy_cnt--;
            if (len_seen) begin busy_cnt = busy_len; post_len = 1; end
            cyc++;
        end
        n_chk++;
        if (!done_seen) begin
            n_fail++; $display("FAIL timeout: got no DONE within %0d cycles, want DONE", cyc);
        end
        @(negedge CLK);
        START = 0; bus.S_VALID = 0; bus.S_LAST = 0; bus.M_BUSY = 0;
        #1;
        n_chk++;
        if (DONE !== 1'b0 || ACTIVE !== 1'b0) begin
            n_fail++; $display("FAIL post_done: got done %b active %b, want 0 0", DONE, ACTIVE);
        end
        n_chk++;
        if (idx != nw) begin
            n_fail++; $display("FAIL words_taken: got %0d want %0d", idx, nw);
        end
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL event_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL event[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
`ifdef SDRAM_STREAM_WR_STATS_EN
        exp_b = 16'(exp_bursts);
`else
        exp_b = 16'd0;
`endif
        n_chk++;
        if (BURSTS !== exp_b) begin
            n_fail++; $display("FAIL bursts: got %0d want %0d", BURSTS, exp_b);
        end
    endtask

    task automatic check_all_zero(input string tag);
        n_chk++;
        if ({bus.S_READY, ACTIVE, DONE, bus.M_WE, bus.M_WE_A, bus.M_WE_LEN} !== 6'd0 ||
            BURSTS !== 16'd0 || bus.M_ADDR !== 8'd0 || bus.M_WD !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: got rdy%b act%b done%b we%b a%b len%b bursts%h addr%h wd%h, want all 0",
                     tag, bus.S_READY, ACTIVE, DONE, bus.M_WE, bus.M_WE_A, bus.M_WE_LEN,
                     BURSTS, bus.M_ADDR, bus.M_WD);
        end
    endtask

    task automatic test_reset();
        RESET = 1; bus.S_VALID = 1; bus.S_DATA = 32'hDEAD_BEEF; bus.S_LAST = 0; bus.M_BUSY = 0;
        repeat (3) @(negedge CLK);
        #1;
        check_all_zero("reset_state");
        @(negedge CLK);
        RESET = 0; bus.S_VALID = 0;
        exp_bursts = 0;
        repeat (2) @(negedge CLK);
        #1;
        check_all_zero("idle_no_start");
    endtask

    task automatic test_two_bursts();
        run_transfer(24'h000100, 8, 3, 100, 0);
        n_chk++;
        if (obs_a.size() != 2 || obs_len.size() != 2) begin
            n_fail++; $display("FAIL two_bursts_count: got %0d/%0d want 2/2", obs_a.size(), obs_len.size());
        end else begin
            n_chk++;
            if (obs_a[0] !== 32'h100 || obs_len[0] !== 32'h8000_0008 ||
                obs_a[1] !== 32'h108 || obs_len[1] !== 32'h8000_0008) begin
                n_fail++;
                $display("FAIL two_bursts_fields: got %h %h %h %h want 100 80000008 108 80000008",
                         obs_a[0], obs_len[0], obs_a[1], obs_len[1]);
            end
        end
    endtask

    task automatic test_short_burst();
        run_transfer(24'h000200, 3, 6, 100, 0);
        n_chk++;
        if (obs_len.size() != 1 || obs_len[0] !== 32'h8000_0006 || obs_q.size() < 3 ||
            obs_q[0].addr !== 8'd0 || obs_q[1].addr !== 8'd1 || obs_q[2].addr !== 8'd2) begin
            n_fail++; $display("FAIL short_burst: got len %h (%0d bursts) want 80000006 with addrs 0,1,2",
                               obs_len.size() ? obs_len[0] : 32'h0, obs_len.size());
        end
    endtask

    task automatic test_single_word();
        run_transfer(24'h123456, 1, 2, 100, 0);
        n_chk++;
        if (obs_len.size() != 1 || obs_len[0] !== 32'h8000_0002) begin
            n_fail++; $display("FAIL single_word: got %h want 80000002", obs_len.size() ? obs_len[0] : 32'h0);
        end
    endtask

    task automatic test_wrap();
        run_transfer(24'hFFFFFC, 8, 2, 80, 0);
        n_chk++;
        if (obs_a.size() != 2 || obs_a[1] !== 32'h0000_0004) begin
            n_fail++; $display("FAIL wrap_addr: got %h want 00000004", obs_a.size() > 1 ? obs_a[1] : 32'h0);
        end
    endtask

    task automatic test_busy_hold();
        run_transfer(24'h000400, 6, 50, 100, 0);
    endtask

    task automatic test_reset_mid();
        run_transfer(24'h000800, 6, 3, 100, 1);
        RESET = 1; bus.M_BUSY = 0; bus.S_VALID = 1;
        @(negedge CLK);
        #1;
        check_all_zero("reset_mid_next");
        @(negedge CLK);
        RESET = 0; bus.S_VALID = 0; START = 0;
        exp_bursts = 0;
        repeat (3) begin
            @(negedge CLK);
            #1;
            check_all_zero("reset_mid_idle");
        end
        run_transfer(24'h000800, 5, 2, 70, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++)
            run_transfer(24'($urandom), $urandom_range(1, 13), $urandom_range(1, 8),
                         $urandom_range(30, 100), 0);
    endtask

    initial begin
        bus.S_VALID = 0; bus.S_DATA = '0; bus.S_LAST = 0; bus.M_BUSY = 0;
        test_reset();
        test_two_bursts();
        test_short_burst();
        test_single_word();
        test_wrap();
        test_busy_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
